// File: rtl/pu_riscv_div_arbiter_if.sv
// Bundle of requester-side and divider-side signals for the shared divider arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface pu_riscv_div_arbiter_if #(
    parameter int XLEN = 64,
    parameter int TAGW = 4
);
    logic [1:0]                 req_valid;
    logic [1:0]                 req_ready;
    logic [1:0][2:0]            req_op;
    logic [1:0][XLEN-1:0]       req_opa;
    logic [1:0][XLEN-1:0]       req_opb;
    logic [1:0][TAGW-1:0]       req_tag;
    logic [1:0]                 flush;
    logic [1:0]                 rsp_valid;
    logic [1:0]                 rsp_ready;
    logic [XLEN-1:0]            rsp_result;
    logic [TAGW-1:0]            rsp_tag;
    logic                       dv_start;
    logic [2:0]                 dv_op;
    logic [XLEN-1:0]            dv_opa;
    logic [XLEN-1:0]            dv_opb;
    logic                       dv_done;
    logic [XLEN-1:0]            dv_result;
    logic                       busy;

    modport slave (
        input  req_valid, req_op, req_opa, req_opb, req_tag, flush, rsp_ready,
               dv_done, dv_result,
        output req_ready, rsp_valid, rsp_result, rsp_tag, dv_start, dv_op,
               dv_opa, dv_opb, busy
    );

    modport master (
        output req_valid, req_op, req_opa, req_opb, req_tag, flush, rsp_ready,
               dv_done, dv_result,
        input  req_ready, rsp_valid, rsp_result, rsp_tag, dv_start, dv_op,
               dv_opa, dv_opb, busy
    );
endinterface

// File: rtl/pu_riscv_div_arbiter.sv
// Round-robin arbiter sharing one iterative divider between two requesters.
// One operation outstanding; a flushed owner's result is drained from the divider and dropped.
//
// state    | meaning
// S_IDLE   | waiting for a request, arbitration active
// S_LAUNCH | one-cycle dv_start pulse with captured operands
// S_WAIT   | divider running, waiting for dv_done
// S_RESP   | result held for the owner until rsp_ready or flush
module pu_riscv_div_arbiter #(
    parameter int XLEN = 64,
    parameter int TAGW = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    pu_riscv_div_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic              owner;
    logic              last;
    logic              kill;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   opa_q;
    logic [XLEN-1:0]   opb_q;
    logic [TAGW-1:0]   tag_q;
    logic [XLEN-1:0]   result_q;
    logic [1:0]        grant;
    logic [1:0]        ready;
    logic [1:0]        rsp_vld;
    logic              accept;
    logic              sel;
    logic              drop;

    // On a tie the requester not served last wins; last resets to 1 so port 0 wins first.
    assign grant[0] = bus.req_valid[0] & (~bus.req_valid[1] | last);
    assign grant[1] = bus.req_valid[1] & (~bus.req_valid[0] | ~last);

    assign accept = (state == S_IDLE) && (ready != 2'b00);
    assign sel    = ready[1];
    assign drop   = kill | bus.flush[owner];

    always_comb begin
        state_nxt = state;
        ready     = 2'b00;
        rsp_vld   = 2'b00;
        case (state)
            S_IDLE: begin
                ready = bus.req_valid & grant & ~bus.flush;
                if (ready != 2'b00) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.dv_done) state_nxt = drop ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                rsp_vld[owner] = ~bus.flush[owner];
                if (bus.flush[owner] || bus.rsp_ready[owner]) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            owner    <= 1'b0;
            last     <= 1'b1;
            kill     <= 1'b0;
            op_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            tag_q    <= '0;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner <= sel;
                last  <= sel;
                op_q  <= bus.req_op[sel];
                opa_q <= bus.req_opa[sel];
                opb_q <= bus.req_opb[sel];
                tag_q <= bus.req_tag[sel];
            end
            if (state == S_WAIT && bus.dv_done) begin
                kill <= 1'b0;
                if (!drop) result_q <= bus.dv_result;
            end else if ((state == S_LAUNCH || state == S_WAIT) && bus.flush[owner]) begin
                kill <= 1'b1;
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.rsp_valid  = rsp_vld;
    assign bus.rsp_result = result_q;
    assign bus.rsp_tag    = tag_q;
    assign bus.dv_start   = (state == S_LAUNCH);
    assign bus.dv_op      = op_q;
    assign bus.dv_opa     = opa_q;
    assign bus.dv_opb     = opb_q;
    assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_pu_riscv_div_arbiter.sv
// Directed bench for the shared-divider arbiter; the divider is played by the tasks,
// which pulse dv_done with hand-computed results.
module tb_pu_riscv_div_arbiter;

    localparam int XLEN = 64;
    localparam int TAGW = 4;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_fail;

    pu_riscv_div_arbiter_if #(.XLEN(XLEN), .TAGW(TAGW)) bus ();

    pu_riscv_div_arbiter #(.XLEN(XLEN), .TAGW(TAGW)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; checks happen 1ns after that.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_opa   = '0;
        bus.req_opb   = '0;
        bus.req_tag   = '0;
        bus.flush     = '0;
        bus.rsp_ready = '0;
        bus.dv_done   = 1'b0;
        bus.dv_result = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rstn = 1'b0;
        repeat (2) tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clear_inputs();
        rstn = 1'b0;
        #12;
        n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got %b exp 00", bus.req_ready); end
        n_checks++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 00", bus.rsp_valid); end
        n_checks++; if (bus.rsp_result !== 64'd0 || bus.rsp_tag !== 4'd0) begin n_fail++; $display("FAIL reset_rsp got %h/%h exp 0/0", bus.rsp_result, bus.rsp_tag); end
        n_checks++; if (bus.dv_start !== 1'b0 || bus.dv_op !== 3'd0) begin n_fail++; $display("FAIL reset_dv got %b/%h exp 0/0", bus.dv_start, bus.dv_op); end
        n_checks++; if (bus.dv_opa !== 64'd0 || bus.dv_opb !== 64'd0) begin n_fail++; $display("FAIL reset_dv_ops got %h/%h exp 0/0", bus.dv_opa, bus.dv_opb); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.req_valid  = 2'b01;
        bus.req_op[0]  = 3'd1;
        bus.req_opa[0] = 64'd100;
        bus.req_opb[0] = 64'd7;
        bus.req_tag[0] = 4'd3;
        #1;
        n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL single_req_ready got %b exp 01", bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        #1;
        n_checks++; if (bus.dv_start !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_dv_start got %b busy %b exp 1/1", bus.dv_start, bus.busy); end
        n_checks++; if (bus.dv_op !== 3'd1 || bus.dv_opa !== 64'd100 || bus.dv_opb !== 64'd7) begin n_fail++; $display("FAIL single_dv_ops got %h %0d %0d exp 1 100 7", bus.dv_op, bus.dv_opa, bus.dv_opb); end
        tick();
        n_checks++; if (bus.dv_start !== 1'b0) begin n_fail++; $display("FAIL single_dv_start_width got %b exp 0", bus.dv_start); end
        repeat (8) tick();
        n_checks++; if (bus.dv_opa !== 64'd100 || bus.dv_opb !== 64'd7 || bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL single_wait_hold got %0d %0d %b exp 100 7 00", bus.dv_opa, bus.dv_opb, bus.rsp_valid); end
        bus.dv_done   = 1'b1;
        bus.dv_result = 64'd14;
        tick();
        bus.dv_done   = 1'b0;
        bus.dv_result = 64'd0;
        #1;
        n_checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 64'd14 || bus.rsp_tag !== 4'd3) begin n_fail++; $display("FAIL single_rsp got %b %0d %0d exp 01 14 3", bus.rsp_valid, bus.rsp_result, bus.rsp_tag); end
        bus.rsp_ready = 2'b01;
        tick();
        bus.rsp_ready = 2'b00;
        #1;
        n_checks++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_done got %b busy %b exp 00/0", bus.rsp_valid, bus.busy); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_grant;
        logic [3:0] exp_tag;
        do_reset();
        bus.req_valid  = 2'b11;
        bus.req_op     = {3'd3, 3'd1};
        bus.req_opa    = {64'd20, 64'd10};
        bus.req_opb    = {64'd3, 64'd2};
        bus.req_tag    = {4'd9, 4'd5};
        bus.rsp_ready  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_grant = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_tag   = (k % 2 == 0) ? 4'd5 : 4'd9;
            #1;
            n_checks++; if (bus.req_ready !== exp_grant) begin n_fail++; $display("FAIL contention_grant%0d got %b exp %b", k, bus.req_ready, exp_grant); end
            tick();
            #1;
            n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL contention_busy_ready%0d got %b exp 00", k, bus.req_ready); end
            tick();
            bus.dv_done   = 1'b1;
            bus.dv_result = 64'(k + 1);
            tick();
            bus.dv_done   = 1'b0;
            #1;
            n_checks++; if (bus.rsp_valid !== exp_grant || bus.rsp_tag !== exp_tag || bus.rsp_result !== 64'(k + 1)) begin n_fail++; $display("FAIL contention_rsp%0d got %b %0d %0d exp %b %0d %0d", k, bus.rsp_valid, bus.rsp_tag, bus.rsp_result, exp_grant, exp_tag, k + 1); end
            tick();
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
    endtask

    task automatic test_back_to_back();
        bus.req_valid  = 2'b10;
        bus.req_op[1]  = 3'd3;
        bus.req_opa[1] = 64'd50;
        bus.req_opb[1] = 64'd8;
        bus.req_tag[1] = 4'd6;
        #1;
        n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_accept1 got %b exp 10", bus.req_ready); end
        tick();
        bus.req_valid  = 2'b01;
        bus.req_op[0]  = 3'd1;
        bus.req_opa[0] = 64'd30;
        bus.req_opb[0] = 64'd5;
        bus.req_tag[0] = 4'd1;
        tick();
        bus.dv_done   = 1'b1;
        bus.dv_result = 64'd2;
        tick();
        bus.dv_done   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_result !== 64'd2 || bus.rsp_tag !== 4'd6 || bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_hold%0d got %b %0d %0d rdy %b exp 10 2 6 00", c, bus.rsp_valid, bus.rsp_result, bus.rsp_tag, bus.req_ready); end
            tick();
        end
        bus.rsp_ready = 2'b10;
        tick();
        bus.rsp_ready = 2'b00;
        #1;
        n_checks++; if (bus.req_ready !== 2'b01 || bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL bp_next_accept got %b rsp %b exp 01 00", bus.req_ready, bus.rsp_valid); end
        tick();
        bus.req_valid = 2'b00;
        #1;
        n_checks++; if (bus.dv_opa !== 64'd30 || bus.dv_op !== 3'd1 || bus.dv_start !== 1'b1) begin n_fail++; $display("FAIL bp_launch0 got %0d %h %b exp 30 1 1", bus.dv_opa, bus.dv_op, bus.dv_start); end
        tick();
        bus.dv_done   = 1'b1;
        bus.dv_result = 64'd6;
        tick();
        bus.dv_done = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 64'd6 || bus.rsp_tag !== 4'd1) begin n_fail++; $display("FAIL bp_rsp0 got %b %0d %0d exp 01 6 1", bus.rsp_valid, bus.rsp_result, bus.rsp_tag); end
        bus.rsp_ready = 2'b01;
        tick();
        bus.rsp_ready = 2'b00;
    endtask

    task automatic test_flush_wait();
        bus.req_valid  = 2'b01;
        bus.req_op[0]  = 3'd0;
        bus.req_opa[0] = 64'd40;
        bus.req_opb[0] = 64'd4;
        bus.req_tag[0] = 4'd2;
        bus.rsp_ready  = 2'b11;
        tick();
        bus.req_valid  = 2'b10;
        bus.req_op[1]  = 3'd1;
        bus.req_opa[1] = 64'd81;
        bus.req_opb[1] = 64'd9;
        bus.req_tag[1] = 4'd7;
        tick();
        bus.flush = 2'b01;
        tick();
        bus.flush = 2'b00;
        repeat (2) tick();
        n_checks++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL flushw_pending got %b busy %b exp 00/1", bus.rsp_valid, bus.busy); end
        bus.dv_done   = 1'b1;
        bus.dv_result = 64'd10;
        tick();
        bus.dv_done = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL flushw_idle got busy %b rsp %b rdy %b exp 0 00 10", bus.busy, bus.rsp_valid, bus.req_ready); end
        tick();
        bus.req_valid = 2'b00;
        #1;
        n_checks++; if (bus.dv_opa !== 64'd81 || bus.dv_opb !== 64'd9) begin n_fail++; $display("FAIL flushw_launch1 got %0d %0d exp 81 9", bus.dv_opa, bus.dv_opb); end
        tick();
        bus.dv_done   = 1'b1;
        bus.dv_result = 64'd9;
        tick();
        bus.dv_done = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_result !== 64'd9 || bus.rsp_tag !== 4'd7) begin n_fail++; $display("FAIL flushw_rsp1 got %b %0d %0d exp 10 9 7", bus.rsp_valid, bus.rsp_result, bus.rsp_tag); end
        tick();
        bus.rsp_ready = 2'b00;
    endtask

    task automatic test_flush_resp();
        bus.req_valid  = 2'b10;
        bus.req_op[1]  = 3'd2;
        bus.req_opa[1] = 64'd17;
        bus.req_opb[1] = 64'd5;
        bus.req_tag[1] = 4'd4;
        tick();
        bus.req_valid = 2'b00;
        tick();
        bus.dv_done   = 1'b1;
        bus.dv_result = 64'd2;
        tick();
        bus.dv_done = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid !== 2'b10 || bus.rsp_tag !== 4'd4) begin n_fail++; $display("FAIL flushr_rsp got %b %0d exp 10 4", bus.rsp_valid, bus.rsp_tag); end
        bus.flush = 2'b10;
        tick();
        bus.flush = 2'b00;
        #1;
        n_checks++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL flushr_drop got %b busy %b exp 00/0", bus.rsp_valid, bus.busy); end
        // last is now 1, so port 0 holds the tie; flushing it must block both ports
        bus.req_valid = 2'b11;
        bus.flush     = 2'b01;
        #1;
        n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL flush_mask got %b exp 00", bus.req_ready); end
        bus.flush = 2'b00;
        #1;
        n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL flush_unmask got %b exp 01", bus.req_ready); end
        bus.req_valid = 2'b00;
        tick();
    endtask

    task automatic test_async_reset();
        bus.req_valid  = 2'b01;
        bus.req_op[0]  = 3'd1;
        bus.req_opa[0] = 64'd9;
        bus.req_opb[0] = 64'd3;
        bus.req_tag[0] = 4'd8;
        tick();
        bus.req_valid = 2'b00;
        tick();
        #2;
        rstn = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b0 || bus.dv_opa !== 64'd0 || bus.dv_op !== 3'd0 || bus.rsp_tag !== 4'd0) begin n_fail++; $display("FAIL areset_outputs got busy %b opa %0d op %h tag %0d exp 0 0 0 0", bus.busy, bus.dv_opa, bus.dv_op, bus.rsp_tag); end
        n_checks++; if (bus.rsp_result !== 64'd0 || bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL areset_rsp got %0d %b %b exp 0 00 00", bus.rsp_result, bus.rsp_valid, bus.req_ready); end
        #1;
        rstn = 1'b1;
        tick();
        bus.dv_done   = 1'b1;
        bus.dv_result = 64'd3;
        tick();
        bus.dv_done = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0 || bus.rsp_result !== 64'd0) begin n_fail++; $display("FAIL areset_stray_done got %b busy %b res %0d exp 00 0 0", bus.rsp_valid, bus.busy, bus.rsp_result); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rstn     = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_flush_wait();
        test_flush_resp();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pu_riscv_div_arbiter.md
# pu_riscv_div_arbiter

Round-robin arbiter and sequencer sharing one iterative integer divider between two requesters (ports 0 and 1, e.g. two hart pipelines or pipeline and debug/accelerator path). Accepts requests with a valid/ready handshake and launches the divider with a one-cycle start pulse. It waits for the divider's done indication and returns the result to the owning requester with a valid/ready handshake. Per-requester flush discards the owner's in-flight operation without corrupting the divider sequence.

## Interface
- XLEN, 64, operand/result width
- TAGW, 4, width of requester-supplied tag returned with the result
- clk  input  1  clock, all state on rising edge
- rstn  input  1  reset, asynchronous, active-low
- req_valid  input  2  request valid, one bit per requester
- req_ready  output  2  request accepted this cycle (one-hot or zero)
- req_op  input  2x3  per requester: 0 DIV, 1 DIVU, 2 REM, 3 REMU, 4 DIVW, 5 DIVUW, 6 REMW, 7 REMUW
- req_opa, req_opb  input  2xXLEN  per requester dividend, divisor
- req_tag  input  2xTAGW  per requester tag
- flush  input  2  per requester kill of pending/in-flight work
- rsp_valid  output  2  result valid for requester i
- rsp_ready  input  2  requester i consumes result
- rsp_result  output  XLEN  result (shared bus, qualified by rsp_valid)
- rsp_tag  output  TAGW  tag of accepted request
- dv_start  output  1  one-cycle launch pulse to divider
- dv_op  output  3  encoding as req_op
- dv_opa, dv_opb  output  XLEN  operands, stable from dv_start until dv_done
- dv_done  input  1  divider result valid, one-cycle pulse
- dv_result  input  XLEN  divider result, valid with dv_done
- busy  output  1  state != IDLE

## Operation
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE: req_ready[i] = req_valid[i] & grant[i] & ~flush[i] (combinational). Grant: if only one valid, that one; if both, the requester not served last (last pointer). Accept -> capture op/opa/opb/tag, owner, last<=owner, go LAUNCH.
- LAUNCH: dv_start=1 for exactly one cycle, dv_* driven from captured registers; go WAIT.
- WAIT: on dv_done: if kill flag clear, latch dv_result into rsp_result, go RESP; if kill set, drop result, clear kill, go IDLE.
- RESP: rsp_valid[owner]=1, rsp_result/rsp_tag stable until rsp_ready[owner]; then go IDLE.
- flush[owner] in LAUNCH or WAIT sets kill (divider completes normally, result discarded). flush[owner] in RESP: drop rsp_valid, go IDLE next cycle. flush of non-owner: no effect on current op; masks that requester's req_ready that cycle.
- dv_done outside WAIT: ignored.
- Arbiter performs no arithmetic; divide-by-zero/overflow handling belongs to the divider.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_result=0, rsp_tag=0, dv_start=0, dv_op=0, dv_opa=0, dv_opb=0, busy=0; state=IDLE, last=1 (requester 0 wins first tie), kill=0.
- Handshake at cycle N -> dv_start at N+1 -> earliest dv_done at N+2.
- dv_done at cycle M -> rsp_valid high at M+1.
- rsp_ready at cycle R (with rsp_valid) -> IDLE at R+1, next req_ready earliest at R+1.
- Minimum accept-to-accept spacing: 4 cycles plus divider latency.
- rstn deassert mid-operation: everything to reset values asynchronously; late dv_done from divider after reset ignored (state IDLE).
- Only one operation outstanding; no buffering.

## Test plan
- Single request: req0 DIVU opa=100 opb=7 tag=3, divider model returns 14 after 10 cycles -> dv_start one pulse at N+1, rsp_valid[0] at done+1, rsp_result=14, rsp_tag=3.
- Contention: both valid every cycle from reset -> grants alternate 0,1,0,1; req_ready never both high.
- Backpressure: hold rsp_ready[1]=0 for 5 cycles -> rsp_valid[1], result, tag stable; req0 not accepted until cycle after rsp_ready[1].
- Flush in WAIT: flush[0] while op 0 pending -> no rsp_valid[0]; after dv_done, IDLE; req1 then accepted and served normally.
- Flush in RESP: flush[1] while rsp_valid[1] -> rsp_valid[1]=0 next cycle, busy=0.
- Async reset in WAIT, stray dv_done afterwards -> all outputs at reset values, no rsp_valid.
